// File: rtl/conv_enc_pkg.sv
// Shared constants, FSM states and helpers for the punctured K=7 convolutional encoder.
// Keep masks use bit 0 for output A and bit 1 for output B.
package conv_enc_pkg;

   localparam int K = 7;
   localparam logic [K-1:0] G0_DEF = 7'o133;
   localparam logic [K-1:0] G1_DEF = 7'o171;

   localparam logic [1:0] MODE_R12 = 2'b00;
   localparam logic [1:0] MODE_R23 = 2'b01;
   localparam logic [1:0] MODE_R34 = 2'b10;

   localparam logic [1:0] KEEP_AB = 2'b11;
   localparam logic [1:0] KEEP_A  = 2'b01;
   localparam logic [1:0] KEEP_B  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD,
      S_LOAD,
      S_ENC,
      S_TAIL,
      S_FLUSH,
      S_DONE
   } state_t;

   // Last phase value before the puncture pattern wraps; mode 11 behaves as rate 1/2.
   function automatic logic [1:0] punct_last(input logic [1:0] mode);
      if (mode == MODE_R23) return 2'd1;
      if (mode == MODE_R34) return 2'd2;
      return 2'd0;
   endfunction

   function automatic logic [1:0] keep_mask(input logic [1:0] mode, input logic [1:0] phase);
      if (phase == 2'd0) return KEEP_AB;
      if (mode == MODE_R23) return KEEP_A;
      if (mode == MODE_R34) return (phase == 2'd1) ? KEEP_A : KEEP_B;
      return KEEP_AB;
   endfunction

   // Generator MSB taps the current bit u, lower bits tap s[0] (newest) .. s[K-2] (oldest).
   function automatic logic conv_parity(input logic [K-1:0] g, input logic u,
                                        input logic [K-2:0] s);
      logic [K-1:0] v;
      v[K-1] = u;
      for (int i = 0; i < K-1; i++) v[K-2-i] = s[i];
      return ^(v & g);
   endfunction

endpackage

// File: rtl/conv_bit_packer.sv
// Packs 0-2 coded bits per cycle LSB-first into OUT_W-bit words; a word is output the cycle
// after it fills, or after flush when a partial word is pending (zero padded in the high bits).
module conv_bit_packer #(
   parameter int OUT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [1:0]       bits,
   input  logic [1:0]       nbits,
   input  logic             flush,
   output logic             word_vld,
   output logic [OUT_W-1:0] word_dat
);

   localparam int CW = $clog2(OUT_W + 1);

   logic [OUT_W-1:0] acc;
   logic [CW-1:0]    cnt;
   logic [OUT_W:0]   merged;
   logic [CW:0]      sum;
   logic [1:0]       keep;

   // merged is one bit wider so the second bit of a pair arriving at OUT_W-1 spills over.
   always_comb begin
      keep   = bits & {nbits == 2'd2, nbits != 2'd0};
      merged = {1'b0, acc} | ((OUT_W+1)'(keep) << cnt);
      sum    = (CW+1)'(cnt) + (CW+1)'(nbits);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         acc      <= '0;
         cnt      <= '0;
         word_vld <= 1'b0;
         word_dat <= '0;
      end else begin
         word_vld <= 1'b0;
         if (clr) begin
            acc <= '0;
            cnt <= '0;
         end else if (flush) begin
            if (cnt != '0) begin
               word_vld <= 1'b1;
               word_dat <= acc;
            end
            acc <= '0;
            cnt <= '0;
         end else if (sum >= (CW+1)'(OUT_W)) begin
            word_vld <= 1'b1;
            word_dat <= merged[OUT_W-1:0];
            acc      <= OUT_W'(merged[OUT_W]);
            cnt      <= CW'(sum - (CW+1)'(OUT_W));
         end else begin
            acc <= merged[OUT_W-1:0];
            cnt <= sum[CW-1:0];
         end
      end
   end

endmodule

// File: rtl/conv_encoder_punct.sv
// K=7 rate-1/2 convolutional encoder with r1/2, r2/3, r3/4 puncturing and optional tail bits.
// Reads words RAM-to-RAM bit-serially (DATA_W+2 cycles per input word); no backpressure.
module conv_encoder_punct
   import conv_enc_pkg::*;
#(
   parameter int           DATA_W = 8,
   parameter int           OUT_W  = 16,
   parameter int           ADDR_W = 5,
   parameter logic [K-1:0] G0     = G0_DEF,
   parameter logic [K-1:0] G1     = G1_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [1:0]        mode,
   input  logic              tail_en,
   input  logic [ADDR_W-1:0] blk_len,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [DATA_W-1:0] rd_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [OUT_W-1:0]  wr_data,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W:0]   wr_count
);

   localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   state_t            state;
   logic [1:0]        mode_q;
   logic              tail_q;
   logic [ADDR_W-1:0] len_q;
   logic [DATA_W-1:0] dreg;
   logic [BW-1:0]     bcnt;
   logic [2:0]        tcnt;
   logic [K-2:0]      sreg;
   logic [1:0]        phase;

   logic       enc_act, u, a_bit, b_bit;
   logic [1:0] keep, pk_bits, pk_n;
   logic       pk_clr, pk_flush;

   always_comb begin
      enc_act = (state == S_ENC) || (state == S_TAIL);
      u       = (state == S_ENC) ? dreg[0] : 1'b0;
      a_bit   = conv_parity(G0, u, sreg);
      b_bit   = conv_parity(G1, u, sreg);
      keep    = keep_mask(mode_q, phase);
      pk_bits = 2'b00;
      pk_n    = 2'd0;
      if (enc_act) begin
         if (keep == KEEP_AB) begin
            pk_bits = {b_bit, a_bit};
            pk_n    = 2'd2;
         end else if (keep == KEEP_A) begin
            pk_bits = {1'b0, a_bit};
            pk_n    = 2'd1;
         end else begin
            pk_bits = {1'b0, b_bit};
            pk_n    = 2'd1;
         end
      end
      pk_clr   = (state == S_IDLE) && start;
      pk_flush = (state == S_FLUSH);
   end

   conv_bit_packer #(.OUT_W(OUT_W)) u_packer (
      .clk      (clk),
      .rst      (rst),
      .clr      (pk_clr),
      .bits     (pk_bits),
      .nbits    (pk_n),
      .flush    (pk_flush),
      .word_vld (wr_en),
      .word_dat (wr_data)
   );

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         mode_q   <= '0;
         tail_q   <= 1'b0;
         len_q    <= '0;
         dreg     <= '0;
         bcnt     <= '0;
         tcnt     <= '0;
         sreg     <= '0;
         phase    <= '0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         wr_addr  <= '0;
         wr_count <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (wr_en) begin
            wr_addr  <= wr_addr + 1'b1;
            wr_count <= wr_count + 1'b1;
         end
         if (enc_act) begin
            sreg  <= {sreg[K-3:0], u};
            phase <= (phase == punct_last(mode_q)) ? 2'd0 : phase + 1'b1;
         end
         case (state)
            S_IDLE: if (start) begin
               mode_q   <= mode;
               tail_q   <= tail_en;
               len_q    <= blk_len;
               sreg     <= '0;
               phase    <= '0;
               rd_addr  <= '0;
               wr_addr  <= '0;
               wr_count <= '0;
               busy     <= 1'b1;
               rd_en    <= 1'b1;
               state    <= S_RD;
            end
            S_RD: begin
               rd_en <= 1'b0;
               state <= S_LOAD;
            end
            S_LOAD: begin
               dreg  <= rd_data;
               bcnt  <= '0;
               state <= S_ENC;
            end
            S_ENC: begin
               dreg <= dreg >> 1;
               bcnt <= bcnt + 1'b1;
               if (bcnt == BW'(DATA_W-1)) begin
                  if (rd_addr == len_q) begin
                     tcnt  <= '0;
                     state <= tail_q ? S_TAIL : S_FLUSH;
                  end else begin
                     rd_addr <= rd_addr + 1'b1;
                     rd_en   <= 1'b1;
                     state   <= S_RD;
                  end
               end
            end
            S_TAIL: begin
               tcnt <= tcnt + 1'b1;
               if (tcnt == 3'(K-2)) state <= S_FLUSH;
            end
            // The partial-word write lands in the DONE cycle, alongside the done pulse.
            S_FLUSH: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Randomized bench for conv_encoder_punct against a convolution-sum reference model.
module tb_conv_encoder_punct;

   localparam int DATA_W = 8;
   localparam int OUT_W  = 16;
   localparam int ADDR_W = 5;
   localparam logic [6:0] GA = 7'o133;
   localparam logic [6:0] GB = 7'o171;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              start = 1'b0;
   logic [1:0]        mode = 2'b00;
   logic              tail_en = 1'b0;
   logic [ADDR_W-1:0] blk_len = '0;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [OUT_W-1:0]  wr_data;
   logic              busy;
   logic              done;
   logic [ADDR_W:0]   wr_count;

   logic [DATA_W-1:0] mem [32];
   logic [OUT_W-1:0]  cap_dat [$];
   logic [ADDR_W-1:0] cap_addr [$];
   logic [OUT_W-1:0]  exp_w [$];
   int done_cnt = 0;
   int total = 0;
   int bad = 0;

   conv_encoder_punct #(.DATA_W(DATA_W), .OUT_W(OUT_W), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .tail_en(tail_en),
      .blk_len(blk_len), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy),
      .done(done), .wr_count(wr_count)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   always @(negedge clk) begin
      if (wr_en) begin
         cap_dat.push_back(wr_data);
         cap_addr.push_back(wr_addr);
      end
      if (done) done_cnt++;
   end

   // Coded bit n = XOR over taps t of g[6-t] * u[n-t], then punctured by n mod period.
   task automatic build_model(input logic [1:0] md, input bit tl, input int nw);
      bit u [$];
      bit c [$];
      bit a, b;
      int p;
      logic [OUT_W-1:0] w;
      exp_w.delete();
      for (int i = 0; i < nw; i++)
         for (int k = 0; k < DATA_W; k++) u.push_back(mem[i][k]);
      if (tl) repeat (6) u.push_back(1'b0);
      p = (md == 2'b01) ? 2 : (md == 2'b10) ? 3 : 1;
      for (int n = 0; n < u.size(); n++) begin
         a = 1'b0;
         b = 1'b0;
         for (int t = 0; t < 7; t++)
            if (n - t >= 0) begin
               a ^= GA[6-t] & u[n-t];
               b ^= GB[6-t] & u[n-t];
            end
         case (n % p)
            0: begin c.push_back(a); c.push_back(b); end
            1: c.push_back(a);
            default: c.push_back(b);
         endcase
      end
      w = '0;
      for (int i = 0; i < c.size(); i++) begin
         w[i % OUT_W] = c[i];
         if (i % OUT_W == OUT_W - 1) begin
            exp_w.push_back(w);
            w = '0;
         end
      end
      if (c.size() % OUT_W != 0) exp_w.push_back(w);
   endtask

   task automatic fill(input bit zeros);
      for (int i = 0; i < 32; i++) mem[i] = zeros ? '0 : DATA_W'($urandom);
   endtask

   task automatic clear_caps();
      cap_dat.delete();
      cap_addr.delete();
      done_cnt = 0;
   endtask

   task automatic launch(input logic [1:0] md, input bit tl, input int len);
      @(negedge clk);
      mode    = md;
      tail_en = tl;
      blk_len = ADDR_W'(len);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
   endtask

   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      rst = 1'b0;
      repeat (3) @(negedge clk);
      total++;
      if ({wr_en, rd_en, busy, done} !== 4'b0) begin
         bad++;
         $display("FAIL reset_strobes: got %b want 0000", {wr_en, rd_en, busy, done});
      end
      total++;
      if ({wr_count, wr_addr, rd_addr, wr_data} !== '0) begin
         bad++;
         $display("FAIL reset_values: got cnt=%0d wa=%0d ra=%0d wd=%h want all 0",
                  wr_count, wr_addr, rd_addr, wr_data);
      end
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_known_vector();
      bit ok;
      fill(1'b1);
      mem[0] = 8'h01;
      clear_caps();
      launch(2'b00, 1'b1, 0);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL known_timeout: got no done want done"); end
      total++;
      if (cap_dat.size() != 2) begin
         bad++;
         $display("FAIL known_nwrites: got %0d want 2", cap_dat.size());
      end else begin
         total++;
         if (cap_dat[0] !== 16'h34FB) begin
            bad++;
            $display("FAIL known_w0: got %h want 34fb", cap_dat[0]);
         end
         total++;
         if (cap_dat[1] !== 16'h0000) begin
            bad++;
            $display("FAIL known_w1: got %h want 0000", cap_dat[1]);
         end
      end
      total++;
      if (wr_count !== 6'd2) begin
         bad++;
         $display("FAIL known_count: got %0d want 2", wr_count);
      end
      total++;
      if (done_cnt != 1 || busy !== 1'b0) begin
         bad++;
         $display("FAIL known_done: got done=%0d busy=%b want 1 0", done_cnt, busy);
      end
   endtask

   task automatic test_encode(input string name, input logic [1:0] md, input bit tl,
                              input int len, input bit zeros, input int exp_n);
      bit ok;
      fill(zeros);
      build_model(md, tl, len + 1);
      clear_caps();
      launch(md, tl, len);
      wait_done(ok);
      total++;
      if (!ok) begin bad++; $display("FAIL %s_timeout: got no done want done", name); end
      total++;
      if (cap_dat.size() != exp_n) begin
         bad++;
         $display("FAIL %s_nwrites: got %0d want %0d", name, cap_dat.size(), exp_n);
      end
      for (int i = 0; i < cap_dat.size() && i < exp_w.size(); i++) begin
         total++;
         if (cap_dat[i] !== exp_w[i] || cap_addr[i] !== ADDR_W'(i)) begin
            bad++;
            $display("FAIL %s_word%0d: got %h@%0d want %h@%0d", name, i,
                     cap_dat[i], cap_addr[i], exp_w[i], i);
         end
      end
      total++;
      if (wr_count !== (ADDR_W+1)'(exp_n)) begin
         bad++;
         $display("FAIL %s_count: got %0d want %0d", name, wr_count, exp_n);
      end
      total++;
      if (done_cnt != 1) begin
         bad++;
         $display("FAIL %s_done: got %0d pulses want 1", name, done_cnt);
      end
   endtask

   task automatic test_start_busy();
      bit ok;
      fill(1'b0);
      build_model(2'b01, 1'b1, 16);
      clear_caps();
      launch(2'b01, 1'b1, 15);
      repeat (20) @(negedge clk);
      mode    = 2'b10;
      tail_en = 1'b0;
      blk_len = 5'd3;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_hold: got %b want 1", busy); end
      wait_done(ok);
      total++;
      if (!ok || cap_dat.size() != 13) begin
         bad++;
         $display("FAIL busy_nwrites: got %0d (done=%b) want 13", cap_dat.size(), ok);
      end
      for (int i = 0; i < cap_dat.size() && i < exp_w.size(); i++) begin
         total++;
         if (cap_dat[i] !== exp_w[i]) begin
            bad++;
            $display("FAIL busy_word%0d: got %h want %h", i, cap_dat[i], exp_w[i]);
         end
      end
      total++;
      if (done_cnt != 1 || wr_count !== 6'd13) begin
         bad++;
         $display("FAIL busy_done: got done=%0d cnt=%0d want 1 13", done_cnt, wr_count);
      end
   endtask

   task automatic test_reset_mid();
      bit ok, seen;
      fill(1'b0);
      clear_caps();
      launch(2'b00, 1'b1, 15);
      seen = 1'b0;
      for (int i = 0; i < 500; i++) begin
         @(negedge clk);
         if (rd_en && rd_addr == 5'd4) begin
            seen = 1'b1;
            break;
         end
      end
      total++;
      if (!seen) begin bad++; $display("FAIL rstmid_reach: got no read of word 4 want read"); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      total++;
      if ({wr_en, rd_en, busy, done, wr_count, wr_addr, rd_addr, wr_data} !== '0) begin
         bad++;
         $display("FAIL rstmid_outputs: got we=%b re=%b busy=%b done=%b cnt=%0d wa=%0d ra=%0d wd=%h want 0",
                  wr_en, rd_en, busy, done, wr_count, wr_addr, rd_addr, wr_data);
      end
      rst = 1'b1;
      clear_caps();
      repeat (60) @(negedge clk);
      total++;
      if (done_cnt != 0 || cap_dat.size() != 0) begin
         bad++;
         $display("FAIL rstmid_quiet: got done=%0d writes=%0d want 0 0", done_cnt, cap_dat.size());
      end
      fill(1'b0);
      build_model(2'b00, 1'b0, 4);
      clear_caps();
      launch(2'b00, 1'b0, 3);
      wait_done(ok);
      total++;
      if (!ok || cap_dat.size() != 4) begin
         bad++;
         $display("FAIL rstmid_restart: got %0d writes (done=%b) want 4", cap_dat.size(), ok);
      end
      for (int i = 0; i < cap_dat.size() && i < exp_w.size(); i++) begin
         total++;
         if (cap_dat[i] !== exp_w[i] || cap_addr[i] !== ADDR_W'(i)) begin
            bad++;
            $display("FAIL rstmid_word%0d: got %h@%0d want %h@%0d", i,
                     cap_dat[i], cap_addr[i], exp_w[i], i);
         end
      end
   endtask

   initial begin
      test_reset();
      test_known_vector();
      test_encode("r12_zero",   2'b00, 1'b1, 15, 1'b1, 17);
      test_encode("r12_notail", 2'b00, 1'b0, 15, 1'b0, 16);
      test_encode("r23",        2'b01, 1'b1, 15, 1'b0, 13);
      test_encode("r34",        2'b10, 1'b1, 15, 1'b0, 12);
      test_encode("r34_len0",   2'b10, 1'b0, 0,  1'b0, 1);
      test_encode("mode11",     2'b11, 1'b1, 15, 1'b0, 17);
      test_start_busy();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
